traffic_light_ctrl_timed: RTL and testbench

- Parametrised highway/farm-road intersection controller. Successor to the fixed-step controller: each phase has a cycle-accurate programmable duration.
- Adds a latched farm-road request, a minimum-green guarantee for the highway, farm green extension with gap-out and max-out, and all-red clearance intervals.
- Sits between the road sensors and the lamp drivers; one instance per intersection.

---
 rtl/traffic_light_ctrl_timed_pkg.sv | 27 ++
 rtl/traffic_light_ctrl_timed_if.sv | 28 ++
 rtl/traffic_light_ctrl_timed_phase_timer.sv | 28 ++
 rtl/traffic_light_ctrl_timed.sv | 155 +++++++++++++++
 tb/tb_traffic_light_ctrl_timed.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_ctrl_timed_pkg.sv
// Shared phase codes, lamp codes and small helpers for the timed intersection controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tlc_pkg;

  typedef logic [2:0] lamp_t;

  // Phase codes; FLASH is only reachable when TLC_FLASH_MODE_EN is defined.
  localparam logic [2:0] HWY_G  = 3'd0;
  localparam logic [2:0] HWY_Y  = 3'd1;
  localparam logic [2:0] AR_1   = 3'd2;
  localparam logic [2:0] FARM_G = 3'd3;
  localparam logic [2:0] FARM_Y = 3'd4;
  localparam logic [2:0] AR_2   = 3'd5;
  localparam logic [2:0] FLASH  = 3'd6;

  // Lamp encoding {red,yellow,green}.
  localparam lamp_t LAMP_RED = 3'b100;
  localparam lamp_t LAMP_YEL = 3'b010;
  localparam lamp_t LAMP_GRN = 3'b001;
  localparam lamp_t LAMP_OFF = 3'b000;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_timed_if.sv
// Sensor inputs and lamp/debug outputs of one intersection controller.
// Latency: n/a (wiring only). flash_mode exists only with TLC_FLASH_MODE_EN.
// Backpressure: none; lamps are level outputs, sensors are level inputs.
interface traffic_light_ctrl_timed_if;
  import tlc_pkg::*;

  logic       farm_car;
`ifdef TLC_FLASH_MODE_EN
  logic       flash_mode;
`endif
  lamp_t      light_highway;
  lamp_t      light_farm;
  logic [2:0] state_o;
  logic       req_pending;

`ifdef TLC_FLASH_MODE_EN
  modport master (output farm_car, output flash_mode,
                  input light_highway, input light_farm, input state_o, input req_pending);
  modport slave  (input farm_car, input flash_mode,
                  output light_highway, output light_farm, output state_o, output req_pending);
`else
  modport master (output farm_car,
                  input light_highway, input light_farm, input state_o, input req_pending);
  modport slave  (input farm_car,
                  output light_highway, output light_farm, output state_o, output req_pending);
`endif

endinterface

// File: rtl/traffic_light_ctrl_timed_phase_timer.sv
// Saturating up-counter: clears to 0 on clear, else counts up and holds at limit.
// Latency: count updates one cycle after clear/advance; at_limit is combinational from count.
// Backpressure: none.
module tlc_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  assign at_limit = (count >= limit);

  // Count up to the limit and stick there; clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count < limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl_timed.sv
// Highway/farm intersection controller with programmable phase durations; TLC_FLASH_MODE_EN adds flash mode.
// Latency: lamps are a Moore decode of the registered phase, changing on the edge the phase changes.
// Backpressure: none; farm_car is latched as a request until the farm green is granted.
module traffic_light_ctrl_timed
  import tlc_pkg::*;
#(
  parameter int T_HWY_MIN    = 16,
  parameter int T_YELLOW     = 4,
  parameter int T_ALL_RED    = 2,
  parameter int T_FARM_MIN   = 6,
  parameter int T_FARM_MAX   = 12,
  parameter int T_FLASH_HALF = 8
) (
  input logic clk,
  input logic rst_n,
  traffic_light_ctrl_timed_if.slave bus
);

  localparam int CNT_W = $clog2(max_of(max_of(T_HWY_MIN, T_YELLOW),
                                       max_of(T_ALL_RED, T_FARM_MAX)) + 1);
  localparam logic [CNT_W-1:0] L_HWY  = CNT_W'(T_HWY_MIN - 1);
  localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_AR   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] L_FMIN = CNT_W'(T_FARM_MIN - 1);
  localparam logic [CNT_W-1:0] L_FMAX = CNT_W'(T_FARM_MAX - 1);

  if (T_HWY_MIN < 1 || T_YELLOW < 1 || T_ALL_RED < 1 || T_FARM_MIN < 1 ||
      T_FARM_MAX < T_FARM_MIN || T_FLASH_HALF < 1) begin : g_bad_params
    $error("traffic_light_ctrl_timed: illegal timing parameters");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             req_q;
  logic             flash_req;
  logic             lamp_lit;
  logic [CNT_W-1:0] ph_limit;
  logic [CNT_W-1:0] ph_cnt;
  logic             ph_at_lim;

`ifdef TLC_FLASH_MODE_EN
  localparam int FL_W = $clog2(T_FLASH_HALF + 1);
  localparam logic [FL_W-1:0] L_FLASH = FL_W'(T_FLASH_HALF - 1);

  logic [FL_W-1:0] fl_cnt;
  logic            fl_at_lim;
  logic            fl_lit;

  assign flash_req = bus.flash_mode;

  // Half-period timer restarts on every toggle and is held clear outside FLASH.
  tlc_phase_timer #(.W(FL_W)) u_flash_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    ((state != FLASH) || fl_at_lim),
    .limit    (L_FLASH),
    .count    (fl_cnt),
    .at_limit (fl_at_lim)
  );

  // Flash starts lit and flips at the end of each half-period.
  always_ff @(posedge clk) begin
    if (!rst_n || state != FLASH) begin
      fl_lit <= 1'b1;
    end else if (fl_cnt == L_FLASH) begin
      fl_lit <= ~fl_lit;
    end
  end

  assign lamp_lit = fl_lit;
`else
  assign flash_req = 1'b0;
  assign lamp_lit  = 1'b1;
`endif

  // Each phase's timer saturates at its own exit point (FARM_G at its max-out point).
  always_comb begin
    ph_limit = '0;
    case (state)
      HWY_G:         ph_limit = L_HWY;
      HWY_Y, FARM_Y: ph_limit = L_YEL;
      AR_1, AR_2:    ph_limit = L_AR;
      FARM_G:        ph_limit = L_FMAX;
      default:       ph_limit = '0;
    endcase
  end

  tlc_phase_timer #(.W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_nxt != state),
    .limit    (ph_limit),
    .count    (ph_cnt),
    .at_limit (ph_at_lim)
  );

  // Phase sequencing; unknown codes recover through all-red, never straight to a green.
  always_comb begin
    state_nxt = state;
    case (state)
      HWY_G:  if (flash_req || (ph_at_lim && req_q)) state_nxt = HWY_Y;
      HWY_Y:  if (ph_at_lim) state_nxt = AR_1;
      AR_1:   if (ph_at_lim) state_nxt = flash_req ? FLASH : FARM_G;
      FARM_G: if (flash_req || (ph_cnt >= L_FMIN && (!bus.farm_car || ph_at_lim)))
                state_nxt = FARM_Y;
      FARM_Y: if (ph_at_lim) state_nxt = AR_2;
      AR_2:   if (ph_at_lim) state_nxt = flash_req ? FLASH : HWY_G;
`ifdef TLC_FLASH_MODE_EN
      FLASH:  if (!flash_req) state_nxt = AR_2;
`endif
      default: state_nxt = AR_2;
    endcase
  end

  // Phase register; reset lands directly in highway green.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HWY_G;
    end else begin
      state <= state_nxt;
    end
  end

  // Farm request latch; granting the farm green clears it even if a car is seen that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else if (state != FARM_G && state_nxt == FARM_G) begin
      req_q <= 1'b0;
    end else if (bus.farm_car && state != FARM_G) begin
      req_q <= 1'b1;
    end
  end

  // Moore lamp decode; any phase other than a green/yellow shows red both ways.
  always_comb begin
    bus.light_highway = LAMP_RED;
    bus.light_farm    = LAMP_RED;
    case (state)
      HWY_G:  bus.light_highway = LAMP_GRN;
      HWY_Y:  bus.light_highway = LAMP_YEL;
      FARM_G: bus.light_farm    = LAMP_GRN;
      FARM_Y: bus.light_farm    = LAMP_YEL;
      FLASH: begin
        bus.light_highway = lamp_lit ? LAMP_YEL : LAMP_OFF;
        bus.light_farm    = lamp_lit ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign bus.state_o     = state;
  assign bus.req_pending = req_q;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// Self-checking bench for traffic_light_ctrl_timed against a cycle-count reference model.
// Latency: model advances on each clk edge, outputs compared 1 time unit later.
// Backpressure: n/a.
module tb_traffic_light_ctrl_timed;

  localparam int T_HWY_MIN    = 16;
  localparam int T_YELLOW     = 4;
  localparam int T_ALL_RED    = 2;
  localparam int T_FARM_MIN   = 6;
  localparam int T_FARM_MAX   = 12;
  localparam int T_FLASH_HALF = 8;

  logic clk = 1'b0;
  logic rst_n;

  traffic_light_ctrl_timed_if bus();

  traffic_light_ctrl_timed #(
    .T_HWY_MIN(T_HWY_MIN), .T_YELLOW(T_YELLOW), .T_ALL_RED(T_ALL_RED),
    .T_FARM_MIN(T_FARM_MIN), .T_FARM_MAX(T_FARM_MAX), .T_FLASH_HALF(T_FLASH_HALF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase number, cycles spent in it (unbounded), latched request.
  int m_ph  = 0;
  int m_el  = 0;
  bit m_req = 1'b0;

  logic [9:0] tr [0:79];

  function automatic bit cur_flash();
`ifdef TLC_FLASH_MODE_EN
    return bus.flash_mode;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input bit rst, input bit car, input bit fl);
    int nx;
    if (!rst) begin
      m_ph = 0; m_el = 0; m_req = 1'b0;
      return;
    end
    nx = m_ph;
    case (m_ph)
      0: if (fl || (m_req && m_el >= T_HWY_MIN - 1)) nx = 1;
      1: if (m_el >= T_YELLOW - 1) nx = 2;
      2: if (m_el >= T_ALL_RED - 1) nx = fl ? 6 : 3;
      3: if (fl || (m_el >= T_FARM_MIN - 1 && (!car || m_el >= T_FARM_MAX - 1))) nx = 4;
      4: if (m_el >= T_YELLOW - 1) nx = 5;
      5: if (m_el >= T_ALL_RED - 1) nx = fl ? 6 : 0;
      6: if (!fl) nx = 5;
      default: nx = 5;
    endcase
    if (nx == 3 && m_ph != 3) m_req = 1'b0;
    else if (car && m_ph != 3) m_req = 1'b1;
    m_el = (nx == m_ph) ? m_el + 1 : 0;
    m_ph = nx;
  endtask

  function automatic logic [9:0] model_vec();
    logic [2:0] h;
    logic [2:0] f;
    bit lit;
    lit = ((m_el / T_FLASH_HALF) % 2) == 0;
    h = 3'b100;
    f = 3'b100;
    case (m_ph)
      0: h = 3'b001;
      1: h = 3'b010;
      3: f = 3'b001;
      4: f = 3'b010;
      6: begin
        h = lit ? 3'b010 : 3'b000;
        f = lit ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
    return {h, f, 3'(m_ph), m_req};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.light_highway, bus.light_farm, bus.state_o, bus.req_pending};
  endfunction

  function automatic int count_code(input int code, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (int'(tr[i][3:1]) == code) c++;
    return c;
  endfunction

  function automatic int first_idx(input int code, input int n);
    for (int i = 0; i < n; i++) if (int'(tr[i][3:1]) == code) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(rst_n, bus.farm_car, cur_flash());
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.farm_car = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    n_tests++;
    if (dut_vec() !== 10'b001_100_000_0) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", dut_vec(), 10'b001_100_000_0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int hold = 0;
    bus.farm_car = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      n_tests++;
      if (dut_vec() !== model_vec() || dut_vec() !== 10'b001_100_000_0) begin
        n_fail++;
        $display("FAIL idle cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (bus.state_o === 3'd0) hold++;
    end
    n_tests++;
    if (hold !== 100) begin
      n_fail++;
      $display("FAIL idle_hold: got %0d want 100", hold);
    end
  endtask

  task automatic test_pulse_request();
    bus.farm_car = 1'b0;
    do_reset();
    tr[0] = dut_vec();
    for (int i = 1; i < 40; i++) begin
      bus.farm_car = (i == 3);
      step();
      tr[i] = dut_vec();
      n_tests++;
      if (tr[i] !== model_vec()) begin
        n_fail++;
        $display("FAIL pulse cyc %0d: got %h want %h", i, tr[i], model_vec());
      end
    end
    bus.farm_car = 1'b0;
    n_tests++;
    if (first_idx(1, 40) !== T_HWY_MIN) begin
      n_fail++;
      $display("FAIL pulse_hwy_len: got %0d want %0d", first_idx(1, 40), T_HWY_MIN);
    end
    n_tests++;
    if (tr[3][0] !== 1'b1 || tr[21][0] !== 1'b1 || tr[22][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_req: got %b%b%b want 110", tr[3][0], tr[21][0], tr[22][0]);
    end
    n_tests++;
    if (count_code(1, 40) !== T_YELLOW || count_code(2, 40) !== T_ALL_RED) begin
      n_fail++;
      $display("FAIL pulse_y_ar: got %0d/%0d want %0d/%0d",
               count_code(1, 40), count_code(2, 40), T_YELLOW, T_ALL_RED);
    end
    n_tests++;
    if (tr[22][3:1] !== 3'd3 || tr[22][9:4] !== 6'b100_001 || count_code(3, 40) !== T_FARM_MIN) begin
      n_fail++;
      $display("FAIL pulse_farm: got %h len %0d want state 3 lamps 100/001 len %0d",
               tr[22], count_code(3, 40), T_FARM_MIN);
    end
  endtask

  task automatic test_maxout();
    bus.farm_car = 1'b1;
    do_reset();
    tr[0] = dut_vec();
    for (int i = 1; i < 60; i++) begin
      step();
      tr[i] = dut_vec();
      n_tests++;
      if (tr[i] !== model_vec()) begin
        n_fail++;
        $display("FAIL maxout cyc %0d: got %h want %h", i, tr[i], model_vec());
      end
    end
    n_tests++;
    if (count_code(3, 60) !== T_FARM_MAX || count_code(4, 60) !== T_YELLOW ||
        count_code(5, 60) !== T_ALL_RED || tr[40][3:1] !== 3'd0) begin
      n_fail++;
      $display("FAIL maxout_len: got %0d/%0d/%0d next %0d want %0d/%0d/%0d next 0",
               count_code(3, 60), count_code(4, 60), count_code(5, 60), tr[40][3:1],
               T_FARM_MAX, T_YELLOW, T_ALL_RED);
    end
    bus.farm_car = 1'b0;
  endtask

  task automatic test_gapout(input int drop);
    int len = 1;
    int want;
    bit got_farm = 1'b0;
    bus.farm_car = 1'b1;
    do_reset();
    for (int i = 0; i < 100 && !got_farm; i++) begin
      step();
      if (bus.state_o === 3'd3) got_farm = 1'b1;
    end
    n_tests++;
    if (!got_farm) begin
      n_fail++;
      $display("FAIL gapout_reach drop %0d: got state %0d want 3", drop, bus.state_o);
      return;
    end
    for (int k = 1; k < 40; k++) begin
      bus.farm_car = (k < drop);
      step();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL gapout cyc %0d: got %h want %h", k, dut_vec(), model_vec());
      end
      if (bus.state_o !== 3'd3) break;
      len++;
    end
    want = (drop < T_FARM_MIN) ? T_FARM_MIN : drop;
    n_tests++;
    if (len !== want) begin
      n_fail++;
      $display("FAIL gapout_len drop %0d: got %0d want %0d", drop, len, want);
    end
    bus.farm_car = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    bus.farm_car = 1'b1;
    do_reset();
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (bus.state_o === 3'd4) hit = 1'b1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got state %0d want 4", bus.state_o);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if (dut_vec() !== 10'b001_100_000_0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want %h", dut_vec(), 10'b001_100_000_0);
    end
    bus.farm_car = 1'b0;
  endtask

  task automatic test_random();
    int dens = 50;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) dens = $urandom_range(0, 100);
      bus.farm_car = ($urandom_range(0, 99) < dens);
      rst_n = ($urandom_range(0, 299) != 0);
`ifdef TLC_FLASH_MODE_EN
      if ($urandom_range(0, 59) == 0) bus.flash_mode = ~bus.flash_mode;
`endif
      step();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    rst_n = 1'b1;
    bus.farm_car = 1'b0;
`ifdef TLC_FLASH_MODE_EN
    bus.flash_mode = 1'b0;
`endif
  endtask

`ifdef TLC_FLASH_MODE_EN
  task automatic test_flash();
    bus.farm_car = 1'b0;
    bus.flash_mode = 1'b0;
    do_reset();
    tr[0] = dut_vec();
    for (int i = 1; i < 40; i++) begin
      bus.flash_mode = (i >= 3 && i < 30);
      step();
      tr[i] = dut_vec();
      n_tests++;
      if (tr[i] !== model_vec()) begin
        n_fail++;
        $display("FAIL flash cyc %0d: got %h want %h", i, tr[i], model_vec());
      end
    end
    bus.flash_mode = 1'b0;
    n_tests++;
    if (tr[3][3:1] !== 3'd1 || tr[7][3:1] !== 3'd2 || tr[9][3:1] !== 3'd6) begin
      n_fail++;
      $display("FAIL flash_entry: got %0d %0d %0d want 1 2 6", tr[3][3:1], tr[7][3:1], tr[9][3:1]);
    end
    n_tests++;
    if (tr[9][9:4] !== 6'b010_100 || tr[16][9:4] !== 6'b010_100 ||
        tr[17][9:4] !== 6'b000_000 || tr[24][9:4] !== 6'b000_000 || tr[25][9:4] !== 6'b010_100) begin
      n_fail++;
      $display("FAIL flash_lamps: got %h %h %h %h %h want 14 14 00 00 14",
               tr[9][9:4], tr[16][9:4], tr[17][9:4], tr[24][9:4], tr[25][9:4]);
    end
    n_tests++;
    if (tr[30][3:1] !== 3'd5 || tr[31][3:1] !== 3'd5 || tr[32][3:1] !== 3'd0) begin
      n_fail++;
      $display("FAIL flash_exit: got %0d %0d %0d want 5 5 0", tr[30][3:1], tr[31][3:1], tr[32][3:1]);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.farm_car = 1'b0;
`ifdef TLC_FLASH_MODE_EN
    bus.flash_mode = 1'b0;
`endif
    #1;
    test_reset();
    test_idle();
    test_pulse_request();
    test_maxout();
    test_gapout(3);
    test_gapout(9);
    test_reset_mid();
`ifdef TLC_FLASH_MODE_EN
    test_flash();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
